// File: rtl/reg_scoreboard.sv
// Counter-based register/CC scoreboard for the decode stage: counts in-flight
// writes between issue and retire and raises dep_stall on pending sources.

module reg_scoreboard_cnt #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             udf
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INFLIGHT);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    // A same-cycle inc and dec cancel and are never checked against the limits.
    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        udf   = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            if (cnt_q == MAX_C) ovf = 1'b1;
            else                cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
            if (cnt_q == '0) udf = 1'b1;
            else             cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

module reg_scoreboard #(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_v,
    input  logic       issue_ld_reg,
    input  logic [2:0] issue_drid,
    input  logic       issue_ld_cc,
    input  logic       retire_v,
    input  logic       retire_ld_reg,
    input  logic [2:0] retire_drid,
    input  logic       retire_ld_cc,
    input  logic       flush,
    input  logic       de_v,
    input  logic [2:0] sr1,
    input  logic       sr1_needed,
    input  logic [2:0] sr2,
    input  logic       sr2_needed,
    input  logic       br_op,
    output logic       dep_stall,
    output logic [7:0] pending_mask,
    output logic       cc_pending,
    output logic       ovf_err,
    output logic       udf_err
);
    localparam int NUM_REGS = 8;

    logic                           inc_r, dec_r, inc_c, dec_c;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            ovf_vec, udf_vec;
    logic [CNT_W-1:0]               cc_cnt;
    logic                           cc_ovf, cc_udf;
    logic                           ovf_err_d, ovf_err_q, udf_err_d, udf_err_q;
    logic                           s1, s2, sb;

    assign inc_r = issue_v  & issue_ld_reg;
    assign dec_r = retire_v & retire_ld_reg;
    assign inc_c = issue_v  & issue_ld_cc;
    assign dec_c = retire_v & retire_ld_cc;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        reg_scoreboard_cnt #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .inc   (inc_r && (issue_drid  == 3'(i))),
            .dec   (dec_r && (retire_drid == 3'(i))),
            .cnt   (cnt[i]),
            .ovf   (ovf_vec[i]),
            .udf   (udf_vec[i])
        );
        assign pending_mask[i] = |cnt[i];
    end

    reg_scoreboard_cnt #(.CNT_W(CNT_W), .MAX_INFLIGHT(MAX_INFLIGHT)) u_cc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .inc   (inc_c),
        .dec   (dec_c),
        .cnt   (cc_cnt),
        .ovf   (cc_ovf),
        .udf   (cc_udf)
    );

    // Error flags survive flush; only reset clears them.
    always_comb begin
        ovf_err_d = ovf_err_q | (|ovf_vec) | cc_ovf;
        udf_err_d = udf_err_q | (|udf_vec) | cc_udf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    // Registered counts only: a same-cycle retire does not release the stall.
    always_comb begin
        s1        = sr1_needed & (cnt[sr1] != '0);
        s2        = sr2_needed & (cnt[sr2] != '0);
        sb        = br_op & (cc_cnt != '0);
        dep_stall = de_v & (s1 | s2 | sb);
    end

    assign cc_pending = |cc_cnt;
    assign ovf_err    = ovf_err_q;
    assign udf_err    = udf_err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed + short random bench for reg_scoreboard; expected registered
// outputs are queued at drive time and popped after the clock edge.

module tb_reg_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n, issue_v, issue_ld_reg, issue_ld_cc;
    logic [2:0] issue_drid, retire_drid, sr1, sr2;
    logic       retire_v, retire_ld_reg, retire_ld_cc, flush;
    logic       de_v, sr1_needed, sr2_needed, br_op;
    logic       dep_stall, cc_pending, ovf_err, udf_err;
    logic [7:0] pending_mask;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] mask;
        logic       cc;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t exp_q[$];
    int   m_cnt[8];
    int   m_cc;
    bit   m_ovf, m_udf;

    always #5 clk = ~clk;

    reg_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_v(issue_v), .issue_ld_reg(issue_ld_reg), .issue_drid(issue_drid),
        .issue_ld_cc(issue_ld_cc),
        .retire_v(retire_v), .retire_ld_reg(retire_ld_reg), .retire_drid(retire_drid),
        .retire_ld_cc(retire_ld_cc),
        .flush(flush), .de_v(de_v),
        .sr1(sr1), .sr1_needed(sr1_needed), .sr2(sr2), .sr2_needed(sr2_needed),
        .br_op(br_op),
        .dep_stall(dep_stall), .pending_mask(pending_mask), .cc_pending(cc_pending),
        .ovf_err(ovf_err), .udf_err(udf_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input bit inc, input bit dec, inout int c);
        if (inc && !dec) begin
            if (c == 3) m_ovf = 1'b1;
            else        c++;
        end else if (dec && !inc) begin
            if (c == 0) m_udf = 1'b1;
            else        c--;
        end
    endtask

    function automatic bit model_stall();
        return de_v && ((sr1_needed && m_cnt[sr1] != 0) ||
                        (sr2_needed && m_cnt[sr2] != 0) ||
                        (br_op && m_cc != 0));
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < 8; i++) e.mask[i] = (m_cnt[i] != 0);
        e.cc  = (m_cc != 0);
        e.ovf = m_ovf;
        e.udf = m_udf;
        return e;
    endfunction

    // One clock: check the combinational stall, advance the model, check state.
    task automatic cyc(input string tag);
        exp_t e;
        #1;
        chk({tag, "_stall"}, {7'd0, dep_stall}, {7'd0, model_stall()});
        if (!rst_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_cc = 0; m_ovf = 0; m_udf = 0;
        end else if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_cc = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                upd(issue_v && issue_ld_reg && issue_drid == 3'(i),
                    retire_v && retire_ld_reg && retire_drid == 3'(i), m_cnt[i]);
            upd(issue_v && issue_ld_cc, retire_v && retire_ld_cc, m_cc);
        end
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s_queue observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_mask"}, pending_mask, e.mask);
            chk({tag, "_cc"},  {7'd0, cc_pending}, {7'd0, e.cc});
            chk({tag, "_ovf"}, {7'd0, ovf_err},    {7'd0, e.ovf});
            chk({tag, "_udf"}, {7'd0, udf_err},    {7'd0, e.udf});
        end
    endtask

    task automatic idle();
        issue_v = 0; issue_ld_reg = 0; issue_ld_cc = 0; issue_drid = 0;
        retire_v = 0; retire_ld_reg = 0; retire_ld_cc = 0; retire_drid = 0;
        flush = 0; de_v = 0; sr1 = 0; sr1_needed = 0; sr2 = 0; sr2_needed = 0; br_op = 0;
    endtask

    task automatic iss(input logic [2:0] d, input bit ldr, input bit ldc);
        issue_v = 1; issue_ld_reg = ldr; issue_drid = d; issue_ld_cc = ldc;
    endtask

    task automatic ret(input logic [2:0] d, input bit ldr, input bit ldc);
        retire_v = 1; retire_ld_reg = ldr; retire_drid = d; retire_ld_cc = ldc;
    endtask

    initial begin
        idle();
        rst_n = 0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_cc = 0; m_ovf = 0; m_udf = 0;
        @(posedge clk);
        cyc("reset");
        chk("reset_mask_const", pending_mask, 8'h00);
        rst_n = 1;

        // Single issue to R3, then source-match stall.
        iss(3, 1, 0); cyc("iss3");
        chk("iss3_mask_const", pending_mask, 8'h08);
        idle(); de_v = 1; sr1 = 3; sr1_needed = 1;
        #1; chk("sr1_3_stall_const", {7'd0, dep_stall}, 8'h01);
        cyc("sr1_3");
        sr1 = 2; cyc("sr1_2");
        // Ignored issue: issue_v low.
        idle(); issue_ld_reg = 1; issue_drid = 4; issue_ld_cc = 1; cyc("ignored");

        // Fill R3 to the limit and overflow, then drain.
        idle(); iss(3, 1, 0); cyc("fill2"); cyc("fill3"); cyc("ovf");
        chk("ovf_const", {7'd0, ovf_err}, 8'h01);
        idle(); ret(3, 1, 0); cyc("drain1"); cyc("drain2"); cyc("drain3");
        chk("drain_mask_const", pending_mask, 8'h00);
        chk("drain_ovf_sticky", {7'd0, ovf_err}, 8'h01);

        // Same-cycle inc/dec on R5, then no retire bypass.
        idle(); iss(5, 1, 0); cyc("r5_one");
        iss(5, 1, 0); ret(5, 1, 0); de_v = 1; sr2 = 5; sr2_needed = 1; cyc("r5_both");
        chk("r5_both_mask", pending_mask, 8'h20);
        issue_v = 0; issue_ld_reg = 0;
        #1; chk("r5_retire_stall_const", {7'd0, dep_stall}, 8'h01);
        cyc("r5_retire");
        retire_v = 0; retire_ld_reg = 0; cyc("r5_release");
        chk("r5_release_const", {7'd0, dep_stall}, 8'h00);

        // Underflow from reset, cleared only by reset.
        idle(); rst_n = 0; cyc("rst2"); rst_n = 1;
        ret(0, 1, 0); cyc("udf");
        chk("udf_const", {7'd0, udf_err}, 8'h01);
        idle(); flush = 1; cyc("udf_flush");
        flush = 0; rst_n = 0; cyc("udf_rst");
        chk("udf_clr_const", {7'd0, udf_err}, 8'h00);
        rst_n = 1;

        // Condition codes.
        iss(0, 0, 1); cyc("cc_iss");
        idle(); de_v = 1; br_op = 1; cyc("cc_br");
        de_v = 0; cyc("cc_nodev");
        idle(); ret(0, 0, 1); cyc("cc_ret");
        chk("cc_ret_const", {7'd0, cc_pending}, 8'h00);

        // Different registers in one cycle, then flush beats a same-cycle issue.
        idle(); iss(1, 1, 1); cyc("f_r1a");
        idle(); iss(1, 1, 0); ret(0, 1, 0); cyc("f_r1b");
        idle(); iss(4, 1, 0); cyc("f_r4");
        chk("f_pre_mask_const", pending_mask, 8'h12);
        idle(); flush = 1; iss(6, 1, 0); cyc("flush");
        idle(); de_v = 1; sr1 = 1; sr1_needed = 1; sr2 = 4; sr2_needed = 1; br_op = 1;
        cyc("post_flush");
        chk("post_flush_mask_const", pending_mask, 8'h00);

        // Short random run against the model.
        for (int n = 0; n < 60; n++) begin
            issue_v = 1'($urandom); issue_ld_reg = 1'($urandom); issue_ld_cc = 1'($urandom);
            issue_drid = 3'($urandom); retire_v = 1'($urandom); retire_ld_reg = 1'($urandom);
            retire_ld_cc = 1'($urandom); retire_drid = 3'($urandom);
            flush = ($urandom_range(0, 15) == 0);
            de_v = 1'($urandom); sr1 = 3'($urandom); sr2 = 3'($urandom);
            sr1_needed = 1'($urandom); sr2_needed = 1'($urandom); br_op = 1'($urandom);
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
